ecb_block_packer: RTL and testbench
===================================

Name: ecb_block_packer

Overview:
- Upstream stage of the ECB AES-128 datapath.
- Accepts the image as a stream of 8-bit bytes and packs each 16 bytes into one 128-bit plaintext block for the combinational AES core.
- Hands each block off through a valid/ready handshake, with a block index and a last-block flag.
- Replaces the file-driven block feed with synthesizable sequential logic, so the datapath can be driven from a byte interface (UART, memory reader).

Parameters:
- NUM_BLOCKS, 65536, number of 128-bit blocks per image frame; range 1 to 2^CNT_W.
- CNT_W, 16, width of the block index counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a new frame.
- in_valid  input  1  in_byte is valid.
- in_ready  output  1  packer accepts a byte this cycle.
- in_byte  input  8  image byte.
- out_valid  output  1  out_block is valid.
- out_ready  input  1  downstream (AES stage) accepts the block.
- out_block  output  128  packed plaintext block, bit order [128:1].
- out_index  output  CNT_W  zero-based index of the presented block.
- out_last  output  1  presented block is the final block of the frame.
- busy  output  1  frame in progress (FILL or HOLD).
- done  output  1  frame complete; held until the next start.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. out_block=0, out_index=0, byte counter=0, out_valid=0, in_ready=0, out_last=0, busy=0, done=0. Reset mid-frame discards any partial block.
- States: IDLE, FILL, HOLD, DONE.
- IDLE:
  - in_ready=0; in_valid is ignored.
  - start -> FILL; clears byte counter and block index.
- FILL:
  - in_ready=1, busy=1.
  - A byte is accepted when in_valid and in_ready are both 1.
  - Byte k (k=0..15 within the block) is written to out_block[128-8k : 121-8k]. The first byte lands in the MSB, so a hex display reads in stream order.
  - On acceptance of byte 15: register the full block, set out_valid=1 on the next edge, go to HOLD, clear the byte counter.
  - Latency: out_valid rises the cycle after the 16th byte is accepted.
- HOLD:
  - in_ready=0; out_valid=1.
  - out_block, out_index and out_last are held stable while out_ready=0.
  - out_last=1 when out_index == NUM_BLOCKS-1.
  - On out_valid and out_ready:
    - if out_last: go to DONE, done=1.
    - else: out_index increments, go to FILL.
  - out_valid drops the next cycle. No combinational path from out_ready to in_ready.
- DONE:
  - done=1, busy=0, in_ready=0.
  - start -> FILL with cleared counters; done falls the same edge.
- start while in FILL or HOLD is ignored.
- Block index counter wraps modulo 2^CNT_W. NUM_BLOCKS=2^CNT_W is legal: last index = all ones.
- in_valid with in_ready=0 is not consumed. The byte source must hold it.

Optional Feature:
- Macro: ECB_PACK_FLUSH_EN.
- Defined:
  - Adds input port flush (1 bit), sampled in FILL only.
  - flush=1 with byte counter > 0:
    - zero-pads the remaining bytes of the current block;
    - goes to HOLD with out_last=1;
    - the frame ends in DONE after the handshake.
  - flush with byte counter == 0 in FILL: go directly to DONE with no block emitted.
  - Simultaneous flush and byte acceptance: the byte is packed first, then padding is applied.
- Not defined: no flush port. A frame ends only after NUM_BLOCKS full blocks.

Test Plan:
- Single block: reset, start, bytes 0x00..0x0F with out_ready=1 -> out_block=128'h000102030405060708090a0b0c0d0e0f, out_index=0, out_valid rises 1 cycle after byte 0x0F.
- Backpressure: full block 0x2b7e1516_28aed2a6_abf71588_09cf4f3c with out_ready=0 for 5 cycles -> block stable, in_ready=0 throughout; out_ready=1 -> in_ready=1 the following cycle.
- Frame end: NUM_BLOCKS=2, two blocks -> out_last=0 then 1; done=1 after the second handshake; further in_valid ignored; start restarts with out_index=0.
- Reset mid-fill: 7 bytes accepted, pulse rst_n low -> all outputs 0, state IDLE; a new start with 16 bytes yields a block with no leftover bytes.
- Ignored input: in_valid with bytes 0xFF before start -> in_ready=0, nothing captured; start ignored during HOLD (out_index unchanged).
- ECB_PACK_FLUSH_EN: bytes AA BB CC then flush -> out_block=128'hAABBCC00_00000000_00000000_00000000, out_last=1, done=1 after handshake.

Source files
------------

// File: rtl/ecb_block_packer.sv
// Packs a byte stream into 128-bit AES plaintext blocks (first byte in MSB); out_valid rises the cycle after byte 15, in_ready=0 while a block waits.
// Optional ECB_PACK_FLUSH_EN adds a flush input that zero-pads the current block and ends the frame early.
module ecb_block_packer #(
  parameter int NUM_BLOCKS = 65536,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef ECB_PACK_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_byte,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_block,
  output logic [CNT_W-1:0] out_index,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_HOLD, S_DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BLOCKS - 1);

  state_t     state, state_nxt;
  logic [3:0] byte_cnt;
  logic       accept;
  logic       blk_full;
  logic       flush_hit;
  logic       flush_last;
  logic       is_last;
  logic       new_frame;

  assign accept    = (state == S_FILL) && in_valid;
  assign blk_full  = accept && (byte_cnt == 4'd15);
  assign new_frame = ((state == S_IDLE) || (state == S_DONE)) && start;
  assign is_last   = (out_index == LAST_IDX) || flush_last;

`ifdef ECB_PACK_FLUSH_EN
  assign flush_hit = (state == S_FILL) && flush;
`else
  assign flush_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_FILL;
      end
      S_FILL: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        // A flush on an empty block with no byte arriving ends the frame without emitting anything.
        if (blk_full || (flush_hit && (accept || byte_cnt != 4'd0))) state_nxt = S_HOLD;
        else if (flush_hit)                                          state_nxt = S_DONE;
      end
      S_HOLD: begin
        out_valid = 1'b1;
        out_last  = is_last;
        busy      = 1'b1;
        if (out_ready) state_nxt = is_last ? S_DONE : S_FILL;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_nxt = S_FILL;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // The block register is cleared before each fill, so flush padding comes for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt   <= 4'd0;
      out_block  <= '0;
      out_index  <= '0;
      flush_last <= 1'b0;
    end else if (new_frame) begin
      byte_cnt   <= 4'd0;
      out_block  <= '0;
      out_index  <= '0;
      flush_last <= 1'b0;
    end else if (state == S_FILL) begin
      if (accept) begin
        out_block[{~byte_cnt, 3'b000} +: 8] <= in_byte;
        byte_cnt                            <= byte_cnt + 4'd1;
      end
      if (state_nxt == S_HOLD) begin
        byte_cnt   <= 4'd0;
        flush_last <= flush_hit;
      end
    end else if ((state == S_HOLD) && out_ready && !is_last) begin
      out_index <= out_index + 1'b1;
      out_block <= '0;
    end
  end

endmodule

// File: tb/tb_ecb_block_packer.sv
// Bench for ecb_block_packer: directed vector table, corner sequences and randomized frames against a byte-stream model.
module tb_ecb_block_packer;
  localparam int NB = 2;
  localparam int CW = 1;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_byte;
  logic          out_valid;
  logic          out_ready;
  logic [127:0]  out_block;
  logic [CW-1:0] out_index;
  logic          out_last;
  logic          busy;
  logic          done;
`ifdef ECB_PACK_FLUSH_EN
  logic          flush;
`endif

  int checks = 0;
  int errors = 0;

  ecb_block_packer #(.NUM_BLOCKS(NB), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef ECB_PACK_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
    .out_index(out_index), .out_last(out_last), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0]  data;
    int            stall;
    logic [127:0]  exp_block;
    logic [CW-1:0] exp_index;
    logic          exp_last;
  } vec_t;

  vec_t vecs[4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    in_valid = 1'b1;
    in_byte  = b;
    while (!in_ready && t < 100) begin
      step();
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_byte_timeout: in_ready got 0 expected 1");
    end
    step();
    in_valid = 1'b0;
  endtask

  // Sends 16 bytes MSB-first with optional idle gaps, checking out_valid latency around the last byte.
  task automatic send16(input logic [127:0] data, input int max_gap);
    logic [127:0] d;
    d = data;
    for (int k = 0; k < 16; k++) begin
      repeat ($urandom_range(0, max_gap)) step();
      if (k == 15) chk("valid_before_last", out_valid, 0);
      send_byte(d[127:120]);
      d = d << 8;
    end
    chk("valid_after_last", out_valid, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_out_index"}, out_index, 0);
    chk({tag, "_out_block"}, out_block, 0);
  endtask

  initial begin
    logic [127:0] exp_blk;
    logic [127:0] held;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00; out_ready = 1'b0;
`ifdef ECB_PACK_FLUSH_EN
    flush = 1'b0;
`endif
    vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 0, 128'h000102030405060708090a0b0c0d0e0f, 1'b0, 1'b0};
    vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 5, 128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1, 1'b1};
    vecs[2] = '{128'h3243f6a8885a308d313198a2e0370734, 1, 128'h3243f6a8885a308d313198a2e0370734, 1'b0, 1'b0};
    vecs[3] = '{128'hffeeddccbbaa99887766554433221100, 2, 128'hffeeddccbbaa99887766554433221100, 1'b1, 1'b1};

    repeat (3) step();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    // Bytes offered before start must be ignored.
    in_valid = 1'b1;
    in_byte  = 8'hFF;
    repeat (3) begin
      step();
      chk("idle_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;

    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        pulse_start();
        chk("start_busy", busy, 1);
        chk("start_done", done, 0);
        chk("start_index", out_index, 0);
      end
      send16(vecs[i].data, 0);
      chk("vec_block", out_block, vecs[i].exp_block);
      chk("vec_index", out_index, vecs[i].exp_index);
      chk("vec_last", out_last, vecs[i].exp_last);
      for (int s = 0; s < vecs[i].stall; s++) begin
        if (s == 2) start = 1'b1;
        step();
        start = 1'b0;
        chk("hold_block", out_block, vecs[i].exp_block);
        chk("hold_index", out_index, vecs[i].exp_index);
        chk("hold_in_ready", in_ready, 0);
        chk("hold_valid", out_valid, 1);
      end
      handshake();
      chk("post_hs_valid", out_valid, 0);
      if (vecs[i].exp_last) begin
        chk("frame_done", done, 1);
        chk("frame_busy", busy, 0);
        in_valid = 1'b1;
        step();
        chk("done_in_ready", in_ready, 0);
        in_valid = 1'b0;
      end else begin
        chk("post_hs_in_ready", in_ready, 1);
      end
    end

    // Reset in the middle of a block.
    pulse_start();
    for (int k = 0; k < 7; k++) send_byte(8'hA0 + 8'(k));
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midrst");
    step();
    rst_n = 1'b1;
    step();
    pulse_start();
    send16(128'h101112131415161718191a1b1c1d1e1f, 0);
    chk("midrst_block", out_block, 128'h101112131415161718191a1b1c1d1e1f);
    chk("midrst_index", out_index, 0);
    handshake();
    send16(128'h202122232425262728292a2b2c2d2e2f, 0);
    chk("midrst_last", out_last, 1);
    chk("midrst_index1", out_index, 1);
    handshake();
    chk("midrst_done", done, 1);

    // Randomized frames: expected blocks are the stream bytes in arrival order, MSB first.
    for (int f = 0; f < 4; f++) begin
      pulse_start();
      for (int b = 0; b < NB; b++) begin
        exp_blk = {$urandom, $urandom, $urandom, $urandom};
        send16(exp_blk, 2);
        chk("rnd_block", out_block, exp_blk);
        chk("rnd_index", out_index, b % (1 << CW));
        chk("rnd_last", out_last, (b == NB - 1));
        held = out_block;
        repeat ($urandom_range(0, 3)) begin
          step();
          chk("rnd_hold", out_block, held);
        end
        handshake();
      end
      chk("rnd_done", done, 1);
    end

`ifdef ECB_PACK_FLUSH_EN
    pulse_start();
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_valid", out_valid, 1);
    chk("flush_block", out_block, 128'hAABBCC00_00000000_00000000_00000000);
    chk("flush_last", out_last, 1);
    handshake();
    chk("flush_done", done, 1);

    pulse_start();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_empty_done", done, 1);
    chk("flush_empty_valid", out_valid, 0);

    pulse_start();
    send_byte(8'h11);
    in_valid = 1'b1;
    in_byte  = 8'h22;
    flush    = 1'b1;
    step();
    in_valid = 1'b0;
    flush    = 1'b0;
    chk("flush_sim_block", out_block, 128'h11220000_00000000_00000000_00000000);
    chk("flush_sim_last", out_last, 1);
    handshake();
    chk("flush_sim_done", done, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
